hyperram_seq: RTL and testbench

Transaction sequencer for the HyperRAM I/O buffer block. It accepts one burst request at a time from a single user port. For each burst it drives chip select, the CK gate (`io_oe_clk`), the DQ output enable (`io_oe_data`) and the 16-bit DDR word (`io_datain`) through the command/address, latency and data phases. It returns read words captured from `io_dataout`. All logic runs in the `clk0` domain; the I/O buffer handles clk90 and RWDS-domain capture.

---
 rtl/hyperram_seq.sv | 160 ++++++++++++++++
 tb/tb_hyperram_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_seq.sv
// rtl/hyperram_seq.sv - HyperRAM burst sequencer: CA, latency, data, hold and read-write recovery phases.
// Optional HRAM_VARIABLE_LATENCY_EN: RWDS level at CA0 selects single or double initial latency.
module hyperram_seq #(
    parameter int LAT_CYCLES = 6,
    parameter int RD_PIPE    = 3,
    parameter int TRWR       = 4
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        cs_n,
    output logic        io_oe_clk,
    output logic        io_oe_data,
    output logic [15:0] io_datain,
    input  logic [15:0] io_dataout,
    input  logic        rwds_in
);
    typedef enum logic [3:0] {IDLE, CSS, CA0, CA1, CA2, LAT, DATA, HOLD, RWR} state_t;

    localparam logic [8:0] LAT_LONG = 9'(2 * LAT_CYCLES);

    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [47:0]        ca_q, ca_d;
    logic [8:0]         len_q, len_d;
    logic [RD_PIPE-1:0] tok_q, tok_d;
    logic               cs_n_q, cs_n_d;
    logic               oe_clk_q, oe_clk_d;
    logic               oe_data_q, oe_data_d;
    logic               wr_ready_q, wr_ready_d;
    logic [15:0]        ca_word_q, ca_word_d;
    logic               done_q, done_d;
    logic [8:0]         lat_len;

`ifdef HRAM_VARIABLE_LATENCY_EN
    logic rwds_q, rwds_d;

    always_comb rwds_d = (state_q == CA0) ? rwds_in : rwds_q;

    always_ff @(posedge clk0) begin
        if (rst) rwds_q <= 1'b0;
        else     rwds_q <= rwds_d;
    end

    assign lat_len = rwds_q ? LAT_LONG : 9'(LAT_CYCLES);
`else
    logic unused_rwds;
    assign unused_rwds = rwds_in;
    assign lat_len     = LAT_LONG;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        ca_d    = ca_q;
        len_d   = len_q;
        done_d  = 1'b0;
        // Each read beat pushes a token; the token leaving the top flags its captured word.
        tok_d   = RD_PIPE'({tok_q, (state_q == DATA) && !write_q});
        unique case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                ca_d    = {~req_write, 1'b0, 1'b1, req_addr[31:3], 13'd0, req_addr[2:0]};
                len_d   = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                state_d = CSS;
            end
            CSS: state_d = CA0;
            CA0: state_d = CA1;
            CA1: state_d = CA2;
            CA2: begin
                state_d = LAT;
                cnt_d   = lat_len - 9'd1;
            end
            LAT: if (cnt_q == 9'd0) begin
                state_d = DATA;
                cnt_d   = len_q - 9'd1;
            end else begin
                cnt_d = cnt_q - 9'd1;
            end
            DATA: if (cnt_q == 9'd0) state_d = HOLD;
                  else               cnt_d   = cnt_q - 9'd1;
            HOLD: begin
                state_d = RWR;
                cnt_d   = 9'(TRWR - 1);
            end
            RWR: if (cnt_q == 9'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - 9'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state they belong to.
        cs_n_d     = (state_d == IDLE) || (state_d == RWR);
        oe_clk_d   = state_d inside {CA0, CA1, CA2, LAT, DATA};
        wr_ready_d = (state_d == DATA) && write_d;
        oe_data_d  = (state_d inside {CA0, CA1, CA2}) || wr_ready_d;
        case (state_d)
            CA0:     ca_word_d = ca_d[47:32];
            CA1:     ca_word_d = ca_d[31:16];
            CA2:     ca_word_d = ca_d[15:0];
            default: ca_word_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            ca_q       <= '0;
            len_q      <= '0;
            tok_q      <= '0;
            cs_n_q     <= 1'b1;
            oe_clk_q   <= 1'b0;
            oe_data_q  <= 1'b0;
            wr_ready_q <= 1'b0;
            ca_word_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            ca_q       <= ca_d;
            len_q      <= len_d;
            tok_q      <= tok_d;
            cs_n_q     <= cs_n_d;
            oe_clk_q   <= oe_clk_d;
            oe_data_q  <= oe_data_d;
            wr_ready_q <= wr_ready_d;
            ca_word_q  <= ca_word_d;
            done_q     <= done_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign cs_n       = cs_n_q;
    assign io_oe_clk  = oe_clk_q;
    assign io_oe_data = oe_data_q;
    assign wr_ready   = wr_ready_q;
    assign done       = done_q;
    // Write data passes straight through so the word lands in the cycle it is consumed.
    assign io_datain  = wr_ready_q ? wr_data : ca_word_q;
    assign rd_valid   = tok_q[RD_PIPE-1];
    assign rd_data    = rd_valid ? io_dataout : 16'h0000;

endmodule

// File: tb/tb_hyperram_seq.sv
// tb/tb_hyperram_seq.sv - randomized self-checking bench for hyperram_seq against a cycle-index timeline model.
module tb_hyperram_seq;
    localparam int LAT_CYCLES = 6;
    localparam int RD_PIPE    = 3;
    localparam int TRWR       = 4;

    logic        clk0 = 1'b0;
    logic        rst, req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_ready, rd_valid, done, cs_n, io_oe_clk, io_oe_data, rwds_in;
    logic [15:0] wr_data, rd_data, io_datain, io_dataout;

    int n_pass  = 0;
    int n_total = 0;

    int          obs_first_wr, obs_wr_cnt, obs_first_rd, obs_rd_cnt, obs_rd_bad;
    int          obs_done, obs_phase_bad, obs_bad_cyc, obs_gap_high;
    logic [15:0] obs_ca [3];
    logic        obs_accept;

    hyperram_seq #(.LAT_CYCLES(LAT_CYCLES), .RD_PIPE(RD_PIPE), .TRWR(TRWR)) dut (
        .clk0(clk0), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .cs_n(cs_n), .io_oe_clk(io_oe_clk), .io_oe_data(io_oe_data),
        .io_datain(io_datain), .io_dataout(io_dataout), .rwds_in(rwds_in)
    );

    always #5 clk0 = ~clk0;

    function automatic int exp_lat(input bit r);
        int full;
        full = 2 * LAT_CYCLES;
`ifdef HRAM_VARIABLE_LATENCY_EN
        return r ? full : LAT_CYCLES;
`else
        return r ? full : full;
`endif
    endfunction

    // Issues one burst (current cycle = accept cycle 0) and records what the DUT did, cycle by cycle,
    // against the timeline: 1 CSS, 2..4 CA, LAT, DATA, 1 HOLD, TRWR recovery, then the done cycle.
    task automatic run_burst(input bit w, input logic [31:0] addr, input logic [7:0] len,
                             input bit rv, input bit hold);
        int n, lat, t_data, t_hold, t_done, cyc;
        logic [15:0] ca [3];
        logic [15:0] e_din;
        bit in_data, e_csn, e_clk, e_oed, e_wrr, e_rdv, e_end;
        n      = (len == 8'd0) ? 256 : int'(len);
        lat    = exp_lat(rv);
        t_data = 5 + lat;
        t_hold = t_data + n;
        t_done = t_hold + 1 + TRWR;
        ca[0]  = 16'((w ? 32'h0 : 32'h8000) + 32'h2000 + (addr >> 19));
        ca[1]  = 16'(addr >> 3);
        ca[2]  = 16'(addr % 8);
        obs_first_wr = -1; obs_wr_cnt = 0; obs_first_rd = -1; obs_rd_cnt = 0; obs_rd_bad = 0;
        obs_done = -1; obs_phase_bad = 0; obs_bad_cyc = -1; obs_gap_high = 0;
        req_write = w; req_addr = addr; req_len = len; rwds_in = rv; req_valid = 1'b1;
        obs_accept = req_ready;
        cyc = 0;
        while (obs_done < 0 && cyc < t_done + 20) begin
            @(posedge clk0); #1;
            cyc++;
            if (!hold) req_valid = 1'b0;
            wr_data    = 16'($urandom);
            io_dataout = 16'($urandom);
            #1;
            in_data = (cyc >= t_data) && (cyc < t_hold);
            e_csn   = !((cyc >= 1) && (cyc <= t_hold));
            e_clk   = (cyc >= 2) && (cyc < t_hold);
            e_wrr   = w && in_data;
            e_oed   = ((cyc >= 2) && (cyc <= 4)) || e_wrr;
            e_rdv   = !w && (cyc >= t_data + RD_PIPE) && (cyc < t_data + RD_PIPE + n);
            e_end   = (cyc == t_done);
            e_din   = ((cyc >= 2) && (cyc <= 4)) ? ca[cyc-2] : (e_wrr ? wr_data : 16'h0);
            if ((cyc >= 2) && (cyc <= 4)) obs_ca[cyc-2] = io_datain;
            if (wr_ready === 1'b1) begin
                if (obs_first_wr < 0) obs_first_wr = cyc;
                obs_wr_cnt++;
            end
            if (rd_valid === 1'b1) begin
                if (obs_first_rd < 0) obs_first_rd = cyc;
                obs_rd_cnt++;
                if (rd_data !== io_dataout) obs_rd_bad++;
            end
            if (done === 1'b1) obs_done = cyc;
            if (cs_n === 1'b1 && cyc > t_hold && cyc < t_done) obs_gap_high++;
            if (cs_n !== e_csn || io_oe_clk !== e_clk || io_oe_data !== e_oed || wr_ready !== e_wrr ||
                rd_valid !== e_rdv || io_datain !== e_din || req_ready !== e_end || done !== e_end) begin
                obs_phase_bad++;
                if (obs_bad_cyc < 0) obs_bad_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        int lowc, dn, rv;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; io_dataout = '0; rwds_in = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        n_total++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n got %b want 1", cs_n); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", req_ready); else n_pass++;
        n_total++;
        if ({io_oe_clk, io_oe_data, wr_ready, rd_valid, done} !== 5'b0 || io_datain !== 16'h0)
            $display("FAIL rst_outputs got %b/%h want 00000/0000",
                     {io_oe_clk, io_oe_data, wr_ready, rd_valid, done}, io_datain);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk0); #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else n_pass++;

        req_write = 1'b1; req_addr = $urandom; req_len = 8'd4; rwds_in = 1'b1; req_valid = 1'b1;
        @(posedge clk0); #1; req_valid = 1'b0;
        @(posedge clk0); #1;
        @(posedge clk0); #1;
        n_total++;
        if ({cs_n, io_oe_clk, io_oe_data} !== 3'b011)
            $display("FAIL mid_ca_active got %b want 011", {cs_n, io_oe_clk, io_oe_data});
        else n_pass++;
        rst = 1'b1;
        @(posedge clk0); #1;
        n_total++;
        if ({cs_n, io_oe_clk, io_oe_data} !== 3'b100 || io_datain !== 16'h0)
            $display("FAIL abort_ca got %b/%h want 100/0000", {cs_n, io_oe_clk, io_oe_data}, io_datain);
        else n_pass++;
        repeat (2) @(posedge clk0);
        #1;
        rst = 1'b0;
        @(posedge clk0); #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", req_ready); else n_pass++;
        lowc = 0; dn = 0;
        repeat (40) begin
            @(posedge clk0); #1;
            if (cs_n !== 1'b1) lowc++;
            if (done !== 1'b0) dn++;
        end
        n_total++; if (lowc != 0) $display("FAIL abort_cs_low got %0d want 0", lowc); else n_pass++;
        n_total++; if (dn != 0) $display("FAIL abort_done got %0d want 0", dn); else n_pass++;

        req_write = 1'b0; req_len = 8'd8; rwds_in = 1'b1; req_valid = 1'b1;
        @(posedge clk0); #1; req_valid = 1'b0;
        repeat (4 + exp_lat(1'b1) + RD_PIPE) @(posedge clk0);
        #1;
        n_total++; if (rd_valid !== 1'b1) $display("FAIL abort_rd_started got %b want 1", rd_valid); else n_pass++;
        rst = 1'b1;
        @(posedge clk0); #1;
        rst = 1'b0;
        rv = 0; dn = 0;
        repeat (20) begin
            @(posedge clk0); #1;
            if (rd_valid !== 1'b0) rv++;
            if (done !== 1'b0) dn++;
        end
        n_total++; if (rv != 0) $display("FAIL abort_rd_valid got %0d want 0", rv); else n_pass++;
        n_total++; if (dn != 0) $display("FAIL abort_rd_done got %0d want 0", dn); else n_pass++;
    endtask

    task automatic test_write_fixed();
        run_burst(1'b1, 32'h0000_1235, 8'd4, 1'b1, 1'b0);
        n_total++; if (obs_accept !== 1'b1) $display("FAIL wr_accept got %b want 1", obs_accept); else n_pass++;
        n_total++; if (obs_ca[0] !== 16'h2000) $display("FAIL wr_ca0 got %h want 2000", obs_ca[0]); else n_pass++;
        n_total++; if (obs_ca[1] !== 16'h0246) $display("FAIL wr_ca1 got %h want 0246", obs_ca[1]); else n_pass++;
        n_total++; if (obs_ca[2] !== 16'h0005) $display("FAIL wr_ca2 got %h want 0005", obs_ca[2]); else n_pass++;
        n_total++; if (obs_first_wr != 17) $display("FAIL wr_first got %0d want 17", obs_first_wr); else n_pass++;
        n_total++; if (obs_wr_cnt != 4) $display("FAIL wr_count got %0d want 4", obs_wr_cnt); else n_pass++;
        n_total++; if (obs_done != 26) $display("FAIL wr_done got %0d want 26", obs_done); else n_pass++;
        n_total++;
        if (obs_phase_bad != 0) $display("FAIL wr_timeline got %0d bad cycles (first %0d) want 0", obs_phase_bad, obs_bad_cyc);
        else n_pass++;
    endtask

    task automatic test_read_fixed();
        run_burst(1'b0, 32'h0000_1235, 8'd2, 1'b1, 1'b0);
        n_total++; if (obs_ca[0] !== 16'hA000) $display("FAIL rd_ca0 got %h want a000", obs_ca[0]); else n_pass++;
        n_total++; if (obs_first_rd != 20) $display("FAIL rd_first got %0d want 20", obs_first_rd); else n_pass++;
        n_total++; if (obs_rd_cnt != 2) $display("FAIL rd_count got %0d want 2", obs_rd_cnt); else n_pass++;
        n_total++; if (obs_rd_bad != 0) $display("FAIL rd_data got %0d bad words want 0", obs_rd_bad); else n_pass++;
        n_total++; if (obs_done != 24) $display("FAIL rd_done got %0d want 24", obs_done); else n_pass++;
        n_total++;
        if (obs_phase_bad != 0) $display("FAIL rd_timeline got %0d bad cycles (first %0d) want 0", obs_phase_bad, obs_bad_cyc);
        else n_pass++;
    endtask

    task automatic test_len_bounds();
        run_burst(1'b0, $urandom, 8'd0, 1'b1, 1'b0);
        n_total++; if (obs_rd_cnt != 256) $display("FAIL len0_count got %0d want 256", obs_rd_cnt); else n_pass++;
        n_total++; if (obs_done != 5 + 12 + 256 + 1 + TRWR) $display("FAIL len0_done got %0d want %0d", obs_done, 5 + 12 + 256 + 1 + TRWR); else n_pass++;
        n_total++; if (obs_phase_bad != 0) $display("FAIL len0_timeline got %0d bad cycles (first %0d) want 0", obs_phase_bad, obs_bad_cyc); else n_pass++;
        run_burst(1'b1, $urandom, 8'd1, 1'b1, 1'b0);
        n_total++; if (obs_wr_cnt != 1) $display("FAIL len1_count got %0d want 1", obs_wr_cnt); else n_pass++;
        n_total++; if (obs_done != 5 + 12 + 1 + 1 + TRWR) $display("FAIL len1_done got %0d want %0d", obs_done, 5 + 12 + 1 + 1 + TRWR); else n_pass++;
        n_total++; if (obs_phase_bad != 0) $display("FAIL len1_timeline got %0d bad cycles (first %0d) want 0", obs_phase_bad, obs_bad_cyc); else n_pass++;
    endtask

    task automatic test_var_latency();
        for (int r = 0; r < 2; r++) begin
            run_burst(1'b1, $urandom, 8'd3, r[0], 1'b0);
            n_total++;
            if (obs_first_wr != 5 + exp_lat(r[0])) $display("FAIL varlat_first rwds=%0d got %0d want %0d", r, obs_first_wr, 5 + exp_lat(r[0]));
            else n_pass++;
            n_total++;
            if (obs_phase_bad != 0) $display("FAIL varlat_timeline rwds=%0d got %0d bad cycles want 0", r, obs_phase_bad);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit w, rv;
        logic [7:0] len;
        for (int i = 0; i < 6; i++) begin
            w = 1'($urandom); rv = 1'($urandom); len = 8'($urandom_range(1, 24));
            run_burst(w, $urandom, len, rv, 1'b0);
            n_total++;
            if (obs_done != 5 + exp_lat(rv) + int'(len) + 1 + TRWR)
                $display("FAIL rand%0d_done got %0d want %0d", i, obs_done, 5 + exp_lat(rv) + int'(len) + 1 + TRWR);
            else n_pass++;
            n_total++;
            if ((w ? obs_wr_cnt : obs_rd_cnt) != int'(len))
                $display("FAIL rand%0d_beats got %0d want %0d", i, w ? obs_wr_cnt : obs_rd_cnt, len);
            else n_pass++;
            n_total++;
            if (obs_phase_bad != 0 || obs_rd_bad != 0)
                $display("FAIL rand%0d_timeline got %0d/%0d bad want 0/0", i, obs_phase_bad, obs_rd_bad);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        run_burst(1'b1, $urandom, 8'd3, 1'b1, 1'b1);
        n_total++; if (obs_phase_bad != 0) $display("FAIL b2b_first_timeline got %0d bad cycles (first %0d) want 0", obs_phase_bad, obs_bad_cyc); else n_pass++;
        n_total++; if (obs_gap_high != TRWR) $display("FAIL b2b_gap got %0d want %0d", obs_gap_high, TRWR); else n_pass++;
        run_burst(1'b0, $urandom, 8'd5, 1'b1, 1'b0);
        n_total++; if (obs_accept !== 1'b1) $display("FAIL b2b_accept got %b want 1", obs_accept); else n_pass++;
        n_total++; if (obs_phase_bad != 0) $display("FAIL b2b_second_timeline got %0d bad cycles (first %0d) want 0", obs_phase_bad, obs_bad_cyc); else n_pass++;
        n_total++; if (obs_rd_cnt != 5 || obs_rd_bad != 0) $display("FAIL b2b_second_rd got %0d/%0d want 5/0", obs_rd_cnt, obs_rd_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_fixed();
        test_read_fixed();
        test_len_bounds();
        test_var_latency();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
